// File: rtl/nv_nvdla_sdp_rdma_arb_pkg.sv
// Shared constants for the SDP read-DMA request arbiter: default sizes, requester IDs, credit width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nv_nvdla_sdp_rdma_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_PD_W       = 79;
    localparam int DEF_CREDIT_MAX = 8;

    // Requester ID encoding, also used on mcif_rd_req_src
    localparam int ID_W = 2;
    localparam logic [ID_W-1:0] ID_MRDMA = 2'd0;
    localparam logic [ID_W-1:0] ID_BRDMA = 2'd1;
    localparam logic [ID_W-1:0] ID_NRDMA = 2'd2;
    localparam logic [ID_W-1:0] ID_ERDMA = 2'd3;

    // Counter wide enough to hold 0..max inclusive
    function automatic int credit_w(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

    localparam int CREDIT_W = credit_w(DEF_CREDIT_MAX);

endpackage

// File: rtl/nv_nvdla_sdp_rdma_rr_pick.sv
// Round-robin picker: first eligible requester after last_grant wins, one-hot plus encoded ID.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module nv_nvdla_sdp_rdma_rr_pick
    import nv_nvdla_sdp_rdma_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
)(
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_id
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Walk the ring starting one past the previous winner; lowest offset eligible wins
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!w_found && i_eligible[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_req_arb.sv
// Credit-gated round-robin merge of SDP read-DMA requests onto one registered MCIF request port.
// Latency: 1 cycle from req_valid&req_ready to mcif_rd_req_valid; 1 request/cycle when the port is ready.
// Backpressure: req_ready only asserts when the output register is empty or draining; optional stall
//               counter is compiled in with NVDLA_SDP_RDMA_ARB_PERF_EN.
module nv_nvdla_sdp_rdma_req_arb
    import nv_nvdla_sdp_rdma_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int PD_W       = DEF_PD_W,
    parameter int CREDIT_MAX = DEF_CREDIT_MAX
)(
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    op_load,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*PD_W-1:0] req_pd,
    input  logic [NUM_REQ-1:0]      cdt_pop,
    output logic                    mcif_rd_req_valid,
    input  logic                    mcif_rd_req_ready,
    output logic [PD_W-1:0]         mcif_rd_req_pd,
    output logic [ID_W-1:0]         mcif_rd_req_src,
    output logic [NUM_REQ-1:0]      credit_empty
`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
    ,
    output logic [31:0]             dp2reg_arb_stall
`endif
);

    localparam int           CW   = credit_w(CREDIT_MAX);
    localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

    logic [CW-1:0]      r_credit [NUM_REQ];
    logic [ID_W-1:0]    r_last_grant;
    logic               r_out_vld;
    logic [PD_W-1:0]    r_out_pd;
    logic [ID_W-1:0]    r_out_src;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_can_load;
    logic               w_accept;

    // A requester may compete only while it holds at least one credit
    always_comb begin
        w_eligible   = '0;
        credit_empty = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            credit_empty[i] = (r_credit[i] == '0);
            w_eligible[i]   = req_valid[i] && (r_credit[i] != '0);
        end
    end

    nv_nvdla_sdp_rdma_rr_pick #(
        .NUM_REQ      (NUM_REQ)
    ) u_rr_pick (
        .i_eligible   (w_eligible),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_id         (w_grant_id)
    );

    // Only hand out a grant when the output slot will be free at the next edge
    assign w_can_load = !r_out_vld || mcif_rd_req_ready;
    assign req_ready  = w_can_load ? w_grant : '0;
    assign w_accept   = |req_ready;

    assign mcif_rd_req_valid = r_out_vld;
    assign mcif_rd_req_pd    = r_out_pd;
    assign mcif_rd_req_src   = r_out_src;

    // Output slot: load the winner, hold under backpressure, empty when drained
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_out_vld <= 1'b0;
            r_out_pd  <= '0;
            r_out_src <= '0;
        end else if (w_accept) begin
            r_out_vld <= 1'b1;
            r_out_pd  <= req_pd[w_grant_id*PD_W +: PD_W];
            r_out_src <= w_grant_id;
        end else if (mcif_rd_req_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    // Round-robin pointer; a layer start wins over a same-cycle grant so requester 0 leads next
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (op_load) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end

    // Per-requester credits: spend on grant, refill on cdt_pop, both together cancel out
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_credit[i] <= CMAX;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({req_ready[i], cdt_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] - CW'(1);
                    2'b01:   if (r_credit[i] != CMAX) r_credit[i] <= r_credit[i] + CW'(1);
                    default: ;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // A credit return with no credit outstanding means the requester and arbiter disagree
    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (nvdla_core_rstn && cdt_pop[i] && !req_ready[i]) begin
                assert (r_credit[i] != CMAX)
                    else $error("credit overflow on requester %0d", i);
            end
        end
    end
`endif

`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
    logic [31:0] r_stall;

    // Count cycles the MCIF port holds us off; saturating, cleared at layer start
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall <= '0;
        end else if (op_load) begin
            r_stall <= '0;
        end else if (r_out_vld && !mcif_rd_req_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign dp2reg_arb_stall = r_stall;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_req_arb.sv
// Directed bench for the SDP read-DMA request arbiter with a reference model and payload scoreboard.
// Latency: inputs change on the falling edge, outputs sampled 1 time unit later.
// Backpressure: mcif_rd_req_ready is driven per scenario to exercise stalls.
module tb_nv_nvdla_sdp_rdma_req_arb;
    import nv_nvdla_sdp_rdma_arb_pkg::*;

    localparam int NR = 4;
    localparam int PW = 79;
    localparam int CM = 8;

    logic              clk        = 1'b0;
    logic              rstn       = 1'b1;
    logic              op_load    = 1'b0;
    logic [NR-1:0]     req_valid  = '0;
    logic [NR-1:0]     cdt_pop    = '0;
    logic [NR*PW-1:0]  req_pd     = '0;
    logic              mcif_ready = 1'b0;
    logic [NR-1:0]     req_ready;
    logic              mcif_valid;
    logic [PW-1:0]     mcif_pd;
    logic [ID_W-1:0]   mcif_src;
    logic [NR-1:0]     credit_empty;
`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
    logic [31:0]       arb_stall;
`endif

    nv_nvdla_sdp_rdma_req_arb #(
        .NUM_REQ           (NR),
        .PD_W              (PW),
        .CREDIT_MAX        (CM)
    ) dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .op_load           (op_load),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_pd            (req_pd),
        .cdt_pop           (cdt_pop),
        .mcif_rd_req_valid (mcif_valid),
        .mcif_rd_req_ready (mcif_ready),
        .mcif_rd_req_pd    (mcif_pd),
        .mcif_rd_req_src   (mcif_src),
        .credit_empty      (credit_empty)
`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
        ,
        .dp2reg_arb_stall  (arb_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] src;
        logic [PW-1:0]   pd;
    } exp_t;

    exp_t            sb[$];
    logic [ID_W-1:0] popped_src[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              m_credit [NR];
    int              m_last;
    int unsigned     m_stall;
    int              dut_acc [NR];
    int              exp_order [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        popped_src.delete();
        for (int i = 0; i < NR; i++) begin
            m_credit[i] = CM;
            dut_acc[i]  = 0;
        end
        m_last  = NR - 1;
        m_stall = 0;
    endtask

    // One clock: check DUT against the model, advance the model as the edge will, then clock
    task automatic step();
        logic [NR-1:0]   exp_rdy;
        logic [NR-1:0]   exp_empty;
        logic [ID_W-1:0] ix;
        logic            can_load;
        int              g;
        exp_t            e;
        for (int i = 0; i < NR; i++) begin
            req_pd[i*PW +: PW] = PW'({$urandom, $urandom, $urandom});
        end
        #1;
        can_load = (sb.size() == 0) || mcif_ready;
        exp_rdy  = '0;
        g        = -1;
        if (can_load) begin
            for (int k = 1; k <= NR; k++) begin
                ix = ID_W'((m_last + k) % NR);
                if (g < 0 && req_valid[ix] && m_credit[ix] > 0) g = int'(ix);
            end
        end
        if (g >= 0) exp_rdy[ID_W'(g)] = 1'b1;
        for (int i = 0; i < NR; i++) exp_empty[i] = (m_credit[i] == 0);
        for (int i = 0; i < NR; i++) dut_acc[i] += int'(req_ready[i] & req_valid[i]);

        chk("req_ready", req_ready, exp_rdy);
        chk("credit_empty", credit_empty, exp_empty);
        chk("out_valid", mcif_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            chk("out_src", mcif_src, sb[0].src);
            chk("out_pd", mcif_pd, sb[0].pd);
        end
`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
        chk("arb_stall", arb_stall, m_stall);
        if (op_load) m_stall = 0;
        else if (sb.size() != 0 && !mcif_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
        if (sb.size() != 0 && mcif_ready) begin
            popped_src.push_back(sb[0].src);
            void'(sb.pop_front());
        end
        if (g >= 0) begin
            e.src = ID_W'(g);
            e.pd  = req_pd[g*PW +: PW];
            sb.push_back(e);
            m_credit[g]--;
            m_last = g;
        end
        for (int i = 0; i < NR; i++) begin
            if (cdt_pop[i] && m_credit[i] < CM) m_credit[i]++;
        end
        if (op_load) m_last = NR - 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        cdt_pop   = '0;
        op_load   = 1'b0;
        rstn      = 1'b0;
        #1;
        chk("rst_out_valid", mcif_valid, 1'b0);
        chk("rst_out_pd", mcif_pd, '0);
        chk("rst_out_src", mcif_src, '0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_credit_empty", credit_empty, '0);
`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
        chk("rst_arb_stall", arb_stall, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        #2;
        do_reset();

        // All four requesters with an always-ready port: strict rotation 0,1,2,3,0
        mcif_ready = 1'b1;
        req_valid  = 4'hF;
        repeat (6) step();
        chk("rr_pop_count", popped_src.size(), 5);
        for (int i = 0; i < 5 && i < popped_src.size(); i++) begin
            chk("rr_order", popped_src[i], exp_order[i]);
        end

        // Requester 3 alone exhausts its 8 credits, then one returned credit buys one request
        do_reset();
        mcif_ready = 1'b1;
        req_valid  = 4'b1000;
        repeat (10) step();
        chk("r3_accepts", dut_acc[3], 8);
        chk("r3_empty", credit_empty[3], 1'b1);
        chk("r3_ready_low", req_ready[3], 1'b0);
        cdt_pop = 4'b1000;
        step();
        cdt_pop = '0;
        repeat (4) step();
        chk("r3_after_pop", dut_acc[3], 9);

        // Port stalled for 5 cycles with a payload held and another requester waiting
        do_reset();
        mcif_ready = 1'b0;
        req_valid  = 4'b0001;
        step();
        req_valid = 4'b0010;
        repeat (5) begin
            step();
            chk("stall_ready_low", req_ready, 4'b0000);
        end
`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
        chk("stall_cnt", arb_stall, 32'd5);
`endif
        mcif_ready = 1'b1;
        step();
        req_valid = '0;
        repeat (2) step();
        mcif_ready = 1'b0;
        req_valid  = 4'b0001;
        repeat (3) step();
        op_load = 1'b1;
        step();
        op_load = 1'b0;
`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
        chk("stall_clr", arb_stall, 32'd0);
`endif
        mcif_ready = 1'b1;
        req_valid  = '0;
        repeat (2) step();

        // Same-cycle grant and credit return on requester 1 at credit 4 leaves 4 credits
        do_reset();
        mcif_ready = 1'b1;
        req_valid  = 4'b0010;
        repeat (4) step();
        cdt_pop = 4'b0010;
        step();
        cdt_pop    = '0;
        dut_acc[1] = 0;
        repeat (6) step();
        chk("r1_credit_kept", dut_acc[1], 4);
        chk("r1_empty", credit_empty[1], 1'b1);

        // op_load after last_grant=1 gives requester 0 priority over 2
        do_reset();
        mcif_ready = 1'b1;
        req_valid  = 4'b0010;
        step();
        req_valid = '0;
        op_load   = 1'b1;
        step();
        op_load   = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("opload_first", req_ready, 4'b0001);
        step();
        // op_load with a grant to 2 in the same cycle: pointer still restarts at 0
        req_valid = 4'b0100;
        op_load   = 1'b1;
        step();
        op_load   = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("opload_after_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();

        // Reset while the output slot is full drops it and refills all credits
        do_reset();
        mcif_ready = 1'b0;
        req_valid  = 4'b0001;
        step();
        req_valid = '0;
        #1;
        chk("pre_rst_valid", mcif_valid, 1'b1);
        do_reset();
        step();
        mcif_ready = 1'b1;
        req_valid  = 4'b0001;
        repeat (10) step();
        chk("r0_full_credit", dut_acc[0], 8);
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_sdp_rdma_req_arb.md
NV_NVDLA_SDP_RDMA_REQ_ARB -- requirements
Module: nv_nvdla_sdp_rdma_req_arb

Interface
REQ-001 Parameter NUM_REQ, 4, number of SDP read-DMA requesters (0=MRDMA, 1=BRDMA, 2=NRDMA, 3=ERDMA).
REQ-002 Parameter PD_W, 79, read-request payload width.
REQ-003 Parameter CREDIT_MAX, 8, maximum outstanding requests per requester.
REQ-004 Reset nvdla_core_rstn, asynchronous, active-low; clock nvdla_core_clk.
REQ-005 nvdla_core_clk  in  1  core clock.
REQ-006 nvdla_core_rstn  in  1  asynchronous active-low reset.
REQ-007 op_load  in  1  layer-start pulse.
REQ-008 req_valid  in  NUM_REQ  per-requester request valid.
REQ-009 req_ready  out  NUM_REQ  per-requester request accept.
REQ-010 req_pd  in  NUM_REQ*PD_W  requester payloads; requester i occupies bits [i*PD_W +: PD_W].
REQ-011 cdt_pop  in  NUM_REQ  per-requester credit return; one credit per cycle high.
REQ-012 mcif_rd_req_valid  out  1  shared request valid.
REQ-013 mcif_rd_req_ready  in  1  shared request accept.
REQ-014 mcif_rd_req_pd  out  PD_W  granted payload.
REQ-015 mcif_rd_req_src  out  2  requester ID of the current payload.
REQ-016 credit_empty  out  NUM_REQ  bit i high when requester i holds zero credits.
REQ-017 dp2reg_arb_stall  out  32  output stall cycle count; present only when the macro in REQ-032 is defined.

Function
REQ-018 Requester i is eligible when req_valid[i] is high and credit[i] > 0.
REQ-019 Arbitration is round-robin: search starts at (last_grant+1) mod NUM_REQ; the first eligible requester wins.
REQ-020 Arbitration occurs only when the output register is empty or popped in the same cycle (mcif_rd_req_valid & mcif_rd_req_ready).
REQ-021 req_ready is one-hot or zero; req_ready[i] is high only for the winner. It is combinational from req_valid, credits, pointer and output-register state.
REQ-022 The winner's payload and ID load the output register at the clock edge, so mcif_rd_req_valid rises exactly 1 cycle after acceptance.
REQ-023 mcif_rd_req_pd and mcif_rd_req_src are held stable while mcif_rd_req_valid is high and mcif_rd_req_ready is low.
REQ-024 Back-to-back throughput is 1 request per cycle when mcif_rd_req_ready stays high.
REQ-025 credit[i] (width clog2(CREDIT_MAX+1)) decrements on grant and increments on cdt_pop[i]. A simultaneous grant and pop leaves it unchanged.
REQ-026 A pop at credit[i]==CREDIT_MAX saturates the counter, and a simulation assertion fires.
REQ-027 op_load sets last_grant to NUM_REQ-1, so requester 0 has first priority; credits and the output register are unaffected.
REQ-028 An op_load in the same cycle as a grant applies the pointer reset after that grant.

Reset
REQ-029 On reset:
- mcif_rd_req_valid=0, mcif_rd_req_pd=0, mcif_rd_req_src=0;
- req_ready=0; credit[i]=CREDIT_MAX; credit_empty=0;
- last_grant=NUM_REQ-1; dp2reg_arb_stall=0.
REQ-030 Reset asserted mid-transfer discards the output register content without a handshake.

Configuration
REQ-031 Stall counting is compiled in or out by a single macro.
REQ-032 With NVDLA_SDP_RDMA_ARB_PERF_EN defined:
- dp2reg_arb_stall increments each cycle mcif_rd_req_valid & !mcif_rd_req_ready;
- it saturates at 0xFFFFFFFF;
- it clears on op_load, with the clear taking priority over the increment.
REQ-033 Without NVDLA_SDP_RDMA_ARB_PERF_EN, the port and counter logic are absent and all other behaviour is identical.

Structure
REQ-034 Package nv_nvdla_sdp_rdma_arb_pkg holds:
- NUM_REQ, PD_W and CREDIT_MAX defaults;
- requester ID constants (ID_MRDMA=0, ID_BRDMA=1, ID_NRDMA=2, ID_ERDMA=3);
- the credit-width constant.
REQ-035 The round-robin picker is the sub-module nv_nvdla_sdp_rdma_rr_pick: combinational, with inputs eligible[NUM_REQ] and last_grant, and outputs a one-hot grant and an encoded ID.

Verification
REQ-036 Reset, then all 4 req_valid=1 with ready held high -> grants in order 0,1,2,3,0; mcif_rd_req_src sequence 0,1,2,3,0, one per cycle.
REQ-037 Requester 3 alone issues 8 requests with no cdt_pop -> 8 accepted, then credit_empty[3]=1 and req_ready[3]=0. One cdt_pop[3] -> exactly 1 more accepted.
REQ-038 mcif_rd_req_ready=0 for 5 cycles with a valid pending -> pd/src stable and req_ready=0 throughout. With the macro defined, dp2reg_arb_stall=5.
REQ-039 Same-cycle grant and cdt_pop on requester 1 at credit 4 -> credit remains 4.
REQ-040 last_grant=1, op_load pulsed, requesters 0 and 2 valid -> requester 0 granted first.
REQ-041 Reset asserted while the output register holds a valid -> mcif_rd_req_valid=0 next cycle and all credits=8.
